// File: rtl/cache_adapter_pkg.sv
// Shared widths, beat indexing and FSM state encoding for the cache line adapter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_adapter_pkg;

    localparam int S_LINE     = 256;
    localparam int S_BURST    = 64;
    localparam int BEATS      = S_LINE / S_BURST;
    localparam int BEAT_IDX_W = 2;

    // Byte offset within a 32-byte line; cleared on the burst address.
    localparam logic [31:0] LINE_OFS_MASK = 32'h0000_001F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adapter_line_buffer.sv
// 256-bit line register: full-line load, beat-indexed 64-bit write and 64-bit read mux.
// Latency: writes visible the cycle after the edge; read mux is combinational.
// Backpressure: none, load takes priority over a beat write in the same cycle.
module adapter_line_buffer
    import cache_adapter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_en,
    input  logic [S_LINE-1:0]     load_line,
    input  logic                  beat_we,
    input  logic [BEAT_IDX_W-1:0] beat_idx,
    input  logic [S_BURST-1:0]    beat_wdata,
    output logic [S_BURST-1:0]    beat_rdata,
    output logic [S_LINE-1:0]     line
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line <= '0;
        end else if (load_en) begin
            line <= load_line;
        end else if (beat_we) begin
            line[int'(beat_idx) * S_BURST +: S_BURST] <= beat_wdata;
        end
    end

    assign beat_rdata = line[int'(beat_idx) * S_BURST +: S_BURST];

endmodule

// File: rtl/cacheline_adapter.sv
// Turns one 256-bit cache line read/write into a 4-beat 64-bit memory burst; optional counters under CACHELINE_ADAPTER_PERF_EN.
// Latency: request sampled at edge 0, pmem_resp pulses in cycle 5 plus one cycle per burst gap.
// Backpressure: burst_resp=0 stalls the current beat indefinitely; the cache holds its request until pmem_resp.
module cacheline_adapter
    import cache_adapter_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pmem_read,
    input  logic                pmem_write,
    input  logic [31:0]         pmem_address,
    input  logic [S_LINE-1:0]   pmem_wdata,
    output logic [S_LINE-1:0]   pmem_rdata,
    output logic                pmem_resp,
    output logic [31:0]         burst_address,
    output logic                burst_read,
    output logic                burst_write,
    output logic [S_BURST-1:0]  burst_wdata,
    input  logic [S_BURST-1:0]  burst_rdata,
    input  logic                burst_resp
`ifdef CACHELINE_ADAPTER_PERF_EN
    ,
    output logic [31:0]         perf_reads,
    output logic [31:0]         perf_writes,
    output logic [31:0]         perf_wait
`endif
);

    state_t                state;
    logic [BEAT_IDX_W-1:0] cnt;
    logic                  last_beat;
    logic [S_BURST-1:0]    wr_beat;
    logic [S_BURST-1:0]    rd_beat_unused;
    logic [S_LINE-1:0]     wr_line_unused;

    assign last_beat = burst_resp && (cnt == BEAT_IDX_W'(BEATS - 1));

    // Separate fill and writeback buffers so pmem_rdata survives an intervening write.
    adapter_line_buffer u_rd_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_en    (1'b0),
        .load_line  ('0),
        .beat_we    ((state == READ) && burst_resp),
        .beat_idx   (cnt),
        .beat_wdata (burst_rdata),
        .beat_rdata (rd_beat_unused),
        .line       (pmem_rdata)
    );

    adapter_line_buffer u_wr_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_en    ((state == IDLE) && pmem_write),
        .load_line  (pmem_wdata),
        .beat_we    (1'b0),
        .beat_idx   (cnt),
        .beat_wdata ('0),
        .beat_rdata (wr_beat),
        .line       (wr_line_unused)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            burst_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Dirty writeback must precede the fill when both are requested.
                    if (pmem_write) begin
                        burst_address <= pmem_address & ~LINE_OFS_MASK;
                        cnt           <= '0;
                        state         <= WRITE;
                    end else if (pmem_read) begin
                        burst_address <= pmem_address & ~LINE_OFS_MASK;
                        cnt           <= '0;
                        state         <= READ;
                    end
                end
                READ, WRITE: begin
                    if (burst_resp) begin
                        cnt <= cnt + BEAT_IDX_W'(1);
                    end
                    if (last_beat) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign pmem_resp   = (state == DONE);
    assign burst_read  = (state == READ);
    assign burst_write = (state == WRITE);
    assign burst_wdata = (state == WRITE) ? wr_beat : '0;

`ifdef CACHELINE_ADAPTER_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_wait   <= '0;
        end else begin
            if ((state == READ) && last_beat && (perf_reads != 32'hFFFF_FFFF)) begin
                perf_reads <= perf_reads + 32'd1;
            end
            if ((state == WRITE) && last_beat && (perf_writes != 32'hFFFF_FFFF)) begin
                perf_writes <= perf_writes + 32'd1;
            end
            if (((state == READ) || (state == WRITE)) && !burst_resp
                    && (perf_wait != 32'hFFFF_FFFF)) begin
                perf_wait <= perf_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: bench-side memory responder plus read-line and write-beat scoreboards.
module tb_cacheline_adapter;

    logic         clk;
    logic         reset_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;
`ifdef CACHELINE_ADAPTER_PERF_EN
    logic [31:0]  perf_reads;
    logic [31:0]  perf_writes;
    logic [31:0]  perf_wait;
`endif

    cacheline_adapter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
`ifdef CACHELINE_ADAPTER_PERF_EN
        ,
        .perf_reads    (perf_reads),
        .perf_writes   (perf_writes),
        .perf_wait     (perf_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_reads = 0;
    int exp_writes = 0;
    int exp_wait = 0;

    logic [255:0] rd_q[$];
    logic [63:0]  wr_q[$];

    logic [255:0] line0, line_w, line_x, line_y, line_z, line_b;
    logic         seen;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_write(input logic [255:0] line);
        for (int k = 0; k < 4; k++) wr_q.push_back(line[64*k +: 64]);
    endtask

    // Entered at the negedge of the first burst cycle; leaves at the negedge of the IDLE cycle after DONE.
    task automatic serve(input bit wr, input logic [255:0] line, input int gaps, input logic [31:0] addr);
        int lat;
        logic [31:0] exp_addr;
        lat = 1;
        exp_addr = {addr[31:5], 5'b0};
        check("burst_address", 256'(burst_address), 256'(exp_addr));
        check("strobes", 256'({burst_write, burst_read}), wr ? 256'(2'b10) : 256'(2'b01));
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gaps; g++) begin
                burst_resp  = 1'b0;
                burst_rdata = {$urandom, $urandom};
                @(negedge clk);
                lat++;
            end
            burst_rdata = line[64*k +: 64];
            burst_resp  = 1'b1;
            if (wr && wr_q.size() > 0) check("burst_wdata", 256'(burst_wdata), 256'(wr_q.pop_front()));
            @(negedge clk);
            lat++;
        end
        burst_resp = 1'b0;
        check("pmem_resp_pulse", 256'(pmem_resp), 256'(1'b1));
        check("latency", 256'(lat), 256'(5 + 4 * gaps));
        if (!wr && rd_q.size() > 0) check("pmem_rdata", pmem_rdata, rd_q.pop_front());
        if (wr) exp_writes++; else exp_reads++;
        exp_wait += 4 * gaps;
        @(negedge clk);
        check("pmem_resp_one_cycle", 256'(pmem_resp), 256'(1'b0));
    endtask

    initial begin
        reset_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_address = '0; pmem_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pmem_resp", 256'(pmem_resp), 256'(1'b0));
        check("rst_strobes", 256'({burst_read, burst_write}), 256'(2'b00));
        check("rst_burst_address", 256'(burst_address), 256'(32'h0));
        check("rst_burst_wdata", 256'(burst_wdata), 256'(64'h0));
        check("rst_pmem_rdata", pmem_rdata, 256'h0);
        reset_n = 1'b1;

        // Read, no gaps.
        line0 = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}};
        rd_q.push_back(line0);
        pmem_read = 1'b1; pmem_address = 32'h0000_1234;
        @(negedge clk);
        check("addr_1220", 256'(burst_address), 256'(32'h0000_1220));
        serve(1'b0, line0, 0, 32'h0000_1234);
        pmem_read = 1'b0;

        // Write with one gap before every beat; read data must survive it.
        line_w = {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}};
        push_write(line_w);
        pmem_write = 1'b1; pmem_wdata = line_w; pmem_address = 32'h8000_0047;
        @(negedge clk);
        check("wbeat0_is_D", 256'(burst_wdata), 256'({16{4'hD}}));
        serve(1'b1, line_w, 1, 32'h8000_0047);
        pmem_write = 1'b0;
        check("rdata_held_after_write", pmem_rdata, line0);

        // Simultaneous read and write: write first, held read follows.
        line_x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        line_y = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        push_write(line_x);
        rd_q.push_back(line_y);
        pmem_write = 1'b1; pmem_read = 1'b1; pmem_wdata = line_x; pmem_address = 32'h0004_0100;
        @(negedge clk);
        serve(1'b1, line_x, 0, 32'h0004_0100);
        pmem_write = 1'b0;
        @(negedge clk);
        serve(1'b0, line_y, 2, 32'h0004_0100);
        pmem_read = 1'b0;

        // Reset after two read beats.
        pmem_read = 1'b1; pmem_address = 32'h0000_2000;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            burst_rdata = {2{$urandom}};
            burst_resp = 1'b1;
            @(negedge clk);
        end
        burst_resp = 1'b0; reset_n = 1'b0; pmem_read = 1'b0;
        @(negedge clk);
        check("abort_burst_read", 256'(burst_read), 256'(1'b0));
        check("abort_pmem_rdata", pmem_rdata, 256'h0);
        reset_n = 1'b1;
        exp_reads = 0; exp_writes = 0; exp_wait = 0;
        seen = pmem_resp;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | pmem_resp | burst_read | burst_write;
        end
        check("abort_no_resp", 256'(seen), 256'(1'b0));

        line_z = {8{$urandom}};
        rd_q.push_back(line_z);
        pmem_read = 1'b1; pmem_address = 32'hDEAD_BEEF;
        @(negedge clk);
        serve(1'b0, line_z, 1, 32'hDEAD_BEEF);
        pmem_read = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | pmem_resp | burst_read | burst_write;
        end
        check("no_duplicate_burst", 256'(seen), 256'(1'b0));

        // Back-to-back write then read with requests held through DONE.
        line_b = {8{$urandom}};
        push_write(line_b);
        pmem_write = 1'b1; pmem_wdata = line_b; pmem_address = 32'h0000_0060;
        @(negedge clk);
        serve(1'b1, line_b, 0, 32'h0000_0060);
        pmem_write = 1'b0;
        rd_q.push_back(line_w);
        pmem_read = 1'b1; pmem_address = 32'h0000_0080;
        @(negedge clk);
        serve(1'b0, line_w, 0, 32'h0000_0080);
        pmem_read = 1'b0;
        @(negedge clk);
        check("idle_after_b2b", 256'({pmem_resp, burst_read, burst_write}), 256'(3'b000));
        check("scoreboards_drained", 256'(rd_q.size() + wr_q.size()), 256'(0));

`ifdef CACHELINE_ADAPTER_PERF_EN
        check("perf_reads", 256'(perf_reads), 256'(exp_reads));
        check("perf_writes", 256'(perf_writes), 256'(exp_writes));
        check("perf_wait", 256'(perf_wait), 256'(exp_wait));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
